apb_spi_xfer_sequencer: RTL

APB bus master that sequences the SPI master's APB register block: after a configuration request it programs the control and baud registers, then performs byte transfers on host request by writing the data register, polling status until the transfer-complete flag sets, and reading back the received byte. It sits between a simple host req/done interface and the `apb_slave_interface` APB port. It is the sole APB master for that slave.

---
 rtl/apb_spi_xfer_sequencer_if.sv | 35 +++
 rtl/apb_spi_xfer_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_spi_xfer_sequencer_if.sv
// APB bus bundle between apb_spi_xfer_sequencer (master) and the SPI
// register block (slave).
//
// Signals:
//   PSEL, PENABLE, PWRITE  master -> slave  APB control
//   PADDR[2:0]             master -> slave  register address
//   PWDATA[7:0]            master -> slave  write data
//   PRDATA[7:0]            slave -> master  read data
//   PREADY                 slave -> master  access complete
//   PSLVERR                slave -> master  access error
//
// Handshake: a transfer is one SETUP cycle (PSEL=1, PENABLE=0) followed by
// ACCESS cycles (PSEL=1, PENABLE=1) until PREADY=1; it completes on the rising
// edge where PENABLE=1 and PREADY=1. PADDR/PWRITE/PWDATA are stable from SETUP
// through completion. PRDATA and PSLVERR are meaningful only on that edge.
interface apb_spi_xfer_sequencer_if;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [2:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_spi_xfer_sequencer.sv
// APB master that programs the SPI master's CR1/CR2/BR registers on request
// and runs byte transfers: write DR, poll SR until SPIF, read DR back.
//
// Ports:
//   PCLK, PRESETn              clock, asynchronous active-low reset
//   cfg_start                  one-cycle request to (re)program CR1/CR2/BR
//   cfg_cr1, cfg_cr2, cfg_br   register values, sampled at acceptance
//   cfg_done                   pulse when configuration completes or aborts
//   xfer_req, xfer_txdata      level transfer request and byte to send
//   xfer_ready                 configured and idle (request accepted now)
//   xfer_done, xfer_rxdata     end-of-transfer pulse and received byte
//   xfer_err                   pulse with cfg_done/xfer_done on error/timeout
//   configured                 last configuration completed without error
//   fsm_state                  current FSM state (debug)
//   apb                        APB master port
module apb_spi_xfer_sequencer #(
    parameter int unsigned POLL_MAX = 255
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       cfg_start,
    input  logic [7:0] cfg_cr1,
    input  logic [7:0] cfg_cr2,
    input  logic [7:0] cfg_br,
    output logic       cfg_done,
    input  logic       xfer_req,
    input  logic [7:0] xfer_txdata,
    output logic       xfer_ready,
    output logic       xfer_done,
    output logic [7:0] xfer_rxdata,
    output logic       xfer_err,
    output logic       configured,
    output logic [2:0] fsm_state,
    apb_spi_xfer_sequencer_if.master apb
);
    localparam logic [2:0] CR1_ADDR  = 3'd0;
    localparam logic [2:0] CR2_ADDR  = 3'd1;
    localparam logic [2:0] BR_ADDR   = 3'd2;
    localparam logic [2:0] SR_ADDR   = 3'd3;
    localparam logic [2:0] DR_ADDR   = 3'd5;
    localparam int         SPIF_BIT  = 7;
    localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CFG_CR1 = 3'd1,
        CFG_CR2 = 3'd2,
        CFG_BR  = 3'd3,
        WR_DR   = 3'd4,
        POLL_SR = 3'd5,
        RD_DR   = 3'd6,
        FINISH  = 3'd7
    } state_t;

    state_t     state, state_next;
    logic       access, access_next;        // 0: SETUP phase, 1: ACCESS phase
    logic       seq_cfg, seq_cfg_next;      // current sequence is configuration
    logic       err, err_next;
    logic       cfg_ok, cfg_ok_next;
    logic [7:0] cr1, cr1_next, cr2, cr2_next, br, br_next, tx, tx_next;
    logic [7:0] poll_cnt, poll_cnt_next;
    logic [7:0] rx, rx_next;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            access   <= 1'b0;
            seq_cfg  <= 1'b0;
            err      <= 1'b0;
            cfg_ok   <= 1'b0;
            cr1      <= '0;
            cr2      <= '0;
            br       <= '0;
            tx       <= '0;
            poll_cnt <= '0;
            rx       <= '0;
        end else begin
            state    <= state_next;
            access   <= access_next;
            seq_cfg  <= seq_cfg_next;
            err      <= err_next;
            cfg_ok   <= cfg_ok_next;
            cr1      <= cr1_next;
            cr2      <= cr2_next;
            br       <= br_next;
            tx       <= tx_next;
            poll_cnt <= poll_cnt_next;
            rx       <= rx_next;
        end
    end

    always_comb begin
        state_next    = state;
        access_next   = access;
        seq_cfg_next  = seq_cfg;
        err_next      = err;
        cfg_ok_next   = cfg_ok;
        cr1_next      = cr1;
        cr2_next      = cr2;
        br_next       = br;
        tx_next       = tx;
        poll_cnt_next = poll_cnt;
        rx_next       = rx;
        case (state)
            IDLE: begin
                access_next = 1'b0;
                err_next    = 1'b0;
                if (cfg_start) begin
                    cr1_next     = cfg_cr1;
                    cr2_next     = cfg_cr2;
                    br_next      = cfg_br;
                    seq_cfg_next = 1'b1;
                    state_next   = CFG_CR1;
                end else if (xfer_req && cfg_ok) begin
                    tx_next       = xfer_txdata;
                    seq_cfg_next  = 1'b0;
                    poll_cnt_next = '0;
                    state_next    = WR_DR;
                end
            end
            FINISH: begin
                access_next = 1'b0;
                state_next  = IDLE;
            end
            default: begin
                if (!access) begin
                    access_next = 1'b1;
                end else if (apb.PREADY) begin
                    // Transfer completes on this edge; the next transfer (if
                    // any) starts with a SETUP cycle while PSEL stays high.
                    access_next = 1'b0;
                    if (apb.PSLVERR) begin
                        err_next   = 1'b1;
                        state_next = FINISH;
                        if (seq_cfg) cfg_ok_next = 1'b0;
                    end else begin
                        case (state)
                            CFG_CR1: state_next = CFG_CR2;
                            CFG_CR2: state_next = CFG_BR;
                            CFG_BR: begin
                                cfg_ok_next = 1'b1;
                                state_next  = FINISH;
                            end
                            WR_DR: state_next = POLL_SR;
                            POLL_SR: begin
                                if (apb.PRDATA[SPIF_BIT]) begin
                                    state_next = RD_DR;
                                end else if (poll_cnt == POLL_LAST) begin
                                    err_next   = 1'b1;
                                    state_next = FINISH;
                                end else begin
                                    poll_cnt_next = poll_cnt + 8'd1;
                                end
                            end
                            RD_DR: begin
                                rx_next    = apb.PRDATA;
                                state_next = FINISH;
                            end
                            default: state_next = FINISH;
                        endcase
                    end
                end
            end
        endcase
    end

    // APB outputs decode straight from registered state, so the asynchronous
    // reset drops PSEL/PENABLE immediately.
    logic       bus_active;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       write;

    always_comb begin
        bus_active = 1'b1;
        addr       = '0;
        wdata      = '0;
        write      = 1'b0;
        case (state)
            CFG_CR1: begin addr = CR1_ADDR; wdata = cr1; write = 1'b1; end
            CFG_CR2: begin addr = CR2_ADDR; wdata = cr2; write = 1'b1; end
            CFG_BR:  begin addr = BR_ADDR;  wdata = br;  write = 1'b1; end
            WR_DR:   begin addr = DR_ADDR;  wdata = tx;  write = 1'b1; end
            POLL_SR: addr = SR_ADDR;
            RD_DR:   addr = DR_ADDR;
            default: bus_active = 1'b0;
        endcase
    end

    assign apb.PSEL    = bus_active;
    assign apb.PENABLE = bus_active & access;
    assign apb.PWRITE  = write;
    assign apb.PADDR   = addr;
    assign apb.PWDATA  = wdata;

    // cfg_start takes priority in IDLE, so a simultaneous xfer_req is not
    // accepted that cycle.
    assign xfer_ready  = (state == IDLE) && cfg_ok && !cfg_start;
    assign cfg_done    = (state == FINISH) && seq_cfg;
    assign xfer_done   = (state == FINISH) && !seq_cfg;
    assign xfer_err    = (state == FINISH) && err;
    assign xfer_rxdata = rx;
    assign configured  = cfg_ok;
    assign fsm_state   = state;
endmodule
